pmem_burst_responder: RTL and testbench

Synthesizable responder for the physical-memory burst protocol driven by the mp4 cache hierarchy (pmem_read/pmem_write/pmem_address/pmem_wdata out, pmem_resp/pmem_rdata in). It holds a line-organized backing store and answers each 32-byte line request with 4 consecutive 64-bit beats after a fixed latency. It replaces the behavioural burst memory for FPGA/emulation builds, and serves as a drop-in bench memory for cache-level tests.

---
 rtl/pmem_pkg.sv | 14 +
 rtl/pmem_line_array.sv | 23 ++
 rtl/pmem_burst_responder.sv | 123 ++++++++++++
 tb/tb_pmem_burst_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// Shared definitions for the physical-memory burst responder: beat geometry and FSM state encoding.
package pmem_pkg;
  localparam int BEAT_W           = 64;
  localparam int BEATS            = 4;
  localparam int BEAT_IDX_W       = 2;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int WAIT_W           = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } pmem_state_t;
endpackage

// File: rtl/pmem_line_array.sv
// Beat-organized backing store: combinational read port, synchronous write port, contents never reset.
module pmem_line_array
  import pmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [BEAT_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [BEAT_W-1:0] rdata_o
);

  logic [BEAT_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pmem_burst_responder.sv
// Answers 32-byte line requests with four 64-bit beats after a fixed latency; flags protocol violations.
module pmem_burst_responder
  import pmem_pkg::*;
#(
  parameter int LATENCY       = 10,
  parameter int LINE_IDX_BITS = 8,
  parameter int BEATS         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [BEAT_W-1:0] pmem_wdata,
  output logic              pmem_resp,
  output logic [BEAT_W-1:0] pmem_rdata,
  output logic              protocol_err
);

  localparam int WORD_W = LINE_IDX_BITS + BEAT_IDX_W;
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

  pmem_state_t              state_q;
  logic                     op_wr_q;
  logic [LINE_IDX_BITS-1:0] line_q;
  logic [WAIT_W-1:0]        wait_q;
  logic [BEAT_IDX_W-1:0]    beat_q;
  logic                     resp_q;
  logic                     err_q;

  logic                     op_active;
  logic [WORD_W-1:0]        word_addr;
  logic                     we;
  logic [BEAT_W-1:0]        mem_rdata;
  logic                     unused_addr;

  // The accepted operation must stay asserted for the whole transaction.
  assign op_active = op_wr_q ? pmem_write : pmem_read;
  assign word_addr = {line_q, beat_q};
  assign we        = resp_q && op_wr_q && pmem_write;

  // Offset bits and bits above the line index deliberately alias.
  assign unused_addr = ^{pmem_address[31:LINE_OFFSET_BITS+LINE_IDX_BITS],
                         pmem_address[LINE_OFFSET_BITS-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      line_q  <= '0;
      wait_q  <= '0;
      beat_q  <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pmem_read && pmem_write) begin
            err_q <= 1'b1;
          end else if (pmem_read || pmem_write) begin
            op_wr_q <= pmem_write;
            line_q  <= pmem_address[LINE_OFFSET_BITS +: LINE_IDX_BITS];
            beat_q  <= '0;
            wait_q  <= WAIT_W'(LATENCY - 1);
            // A single-cycle latency skips WAIT so the first beat lands in the next cycle.
            if (LATENCY == 1) begin
              state_q <= BURST;
              resp_q  <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!op_active) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q - 1'b1;
            if (wait_q == WAIT_W'(1)) begin
              state_q <= BURST;
              resp_q  <= 1'b1;
            end
          end
        end
        BURST: begin
          if (!op_active) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
            resp_q  <= 1'b0;
            beat_q  <= '0;
          end else if (beat_q == LAST_BEAT) begin
            state_q <= IDLE;
            resp_q  <= 1'b0;
            beat_q  <= '0;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  pmem_line_array #(
    .ADDR_W(WORD_W)
  ) u_array (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (word_addr),
    .wdata_i (pmem_wdata),
    .raddr_i (word_addr),
    .rdata_o (mem_rdata)
  );

  assign pmem_resp    = resp_q;
  assign pmem_rdata   = (resp_q && !op_wr_q) ? mem_rdata : '0;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Scoreboard bench for pmem_burst_responder at LATENCY 10, 1 and 37.
module tb_pmem_burst_responder;

  typedef struct {
    bit          is_rd;
    logic [63:0] data;
  } exp_t;

  localparam int LAT [3] = '{10, 1, 37};

  logic        clk;
  logic        rst   [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] addr  [3];
  logic [63:0] wdata [3];
  logic        resp  [3];
  logic [63:0] rdata [3];
  logic        perr  [3];

  exp_t sb [3][$];
  int   tests = 0;
  int   fails = 0;

  pmem_burst_responder #(.LATENCY(10), .LINE_IDX_BITS(8), .BEATS(4)) u_dut (
    .clk(clk), .rst(rst[0]), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wdata[0]), .pmem_resp(resp[0]),
    .pmem_rdata(rdata[0]), .protocol_err(perr[0]));

  pmem_burst_responder #(.LATENCY(1), .LINE_IDX_BITS(8), .BEATS(4)) u_lat1 (
    .clk(clk), .rst(rst[1]), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wdata[1]), .pmem_resp(resp[1]),
    .pmem_rdata(rdata[1]), .protocol_err(perr[1]));

  pmem_burst_responder #(.LATENCY(37), .LINE_IDX_BITS(8), .BEATS(4)) u_lat37 (
    .clk(clk), .rst(rst[2]), .pmem_read(rd[2]), .pmem_write(wr[2]),
    .pmem_address(addr[2]), .pmem_wdata(wdata[2]), .pmem_resp(resp[2]),
    .pmem_rdata(rdata[2]), .protocol_err(perr[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every resp pops one expected beat; idle cycles must show rdata=0.
  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < 3; u++) begin
      if (resp[u]) begin
        if (sb[u].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp u%0d: got resp=1 rdata=%h expected no resp", u, rdata[u]);
        end else begin
          e = sb[u].pop_front();
          if (e.is_rd) begin
            tests++;
            if (rdata[u] !== e.data) begin
              fails++;
              $display("FAIL read_beat u%0d: got %h expected %h", u, rdata[u], e.data);
            end
          end
        end
      end else if (!rst[u]) begin
        tests++;
        if (rdata[u] !== 64'h0) begin
          fails++;
          $display("FAIL rdata_idle_zero u%0d: got %h expected 0", u, rdata[u]);
        end
      end
    end
  end

  // Initiator: issues one line transaction; stop_at<4 drops the op (or resets) after that many beats.
  task automatic txn(input int u, input bit is_wr, input logic [31:0] a, input logic [31:0] a2,
                     input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                     input logic [63:0] d3, input int stop_at, input bit do_rst);
    logic [63:0] dd [4];
    exp_t e;
    int n, beat, nexp;
    dd[0] = d0; dd[1] = d1; dd[2] = d2; dd[3] = d3;
    nexp = (stop_at >= 4) ? 4 : (do_rst ? stop_at : stop_at + 1);
    for (int k = 0; k < nexp; k++) begin
      e.is_rd = !is_wr;
      e.data  = dd[k];
      sb[u].push_back(e);
    end
    addr[u]  = a;
    wdata[u] = dd[0];
    rd[u]    = !is_wr;
    wr[u]    = is_wr;
    @(posedge clk);
    #1 addr[u] = a2;
    n = 0;
    beat = 0;
    while (beat < stop_at && n < LAT[u] + 8) begin
      @(negedge clk);
      n++;
      if (resp[u]) begin
        if (beat == 0) chk("first_resp_latency", 64'(n), 64'(LAT[u]));
        beat++;
        @(posedge clk);
        #1;
        if (beat < 4) wdata[u] = dd[beat];
        if (beat == stop_at) begin
          if (do_rst) begin
            rst[u] = 1'b1;
            #1 chk("async_reset_resp", 64'(resp[u]), 64'h0);
          end
          rd[u] = 1'b0;
          wr[u] = 1'b0;
        end
      end else if (beat > 0) begin
        chk("resp_consecutive", 64'(resp[u]), 64'h1);
        rd[u] = 1'b0;
        wr[u] = 1'b0;
        break;
      end
    end
    if (beat == 0) begin
      chk("resp_timeout", 64'(beat), 64'(stop_at));
      rd[u] = 1'b0;
      wr[u] = 1'b0;
    end
    if (do_rst) begin
      @(posedge clk);
      #1 rst[u] = 1'b0;
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1; rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wdata[u] = '0;
    end
    idle(2);
    for (int u = 0; u < 3; u++) rst[u] = 1'b0;
    idle(1);
    for (int u = 0; u < 3; u++) begin
      chk("reset_resp", 64'(resp[u]), 64'h0);
      chk("reset_rdata", rdata[u], 64'h0);
      chk("reset_err", 64'(perr[u]), 64'h0);
    end

    // Write-then-read on line 0x40.
    txn(0, 1, 32'h40, 32'h40, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 4, 0);
    idle(2);
    txn(0, 0, 32'h40, 32'h40, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 4, 0);
    idle(2);

    // Alias: 0x2040 and 0x005F both select line index 2.
    txn(0, 1, 32'h2040, 32'h2040, 64'hA1A1_0000_0000_0001, 64'hA2A2_0000_0000_0002,
        64'hA3A3_0000_0000_0003, 64'hA4A4_0000_0000_0004, 4, 0);
    idle(2);
    txn(0, 0, 32'h005F, 32'h005F, 64'hA1A1_0000_0000_0001, 64'hA2A2_0000_0000_0002,
        64'hA3A3_0000_0000_0003, 64'hA4A4_0000_0000_0004, 4, 0);
    idle(2);

    // Illegal read+write for one cycle; array must be untouched.
    addr[0] = 32'h40; wdata[0] = 64'hDEAD_BEEF_DEAD_BEEF; rd[0] = 1'b1; wr[0] = 1'b1;
    @(posedge clk);
    #1 rd[0] = 1'b0; wr[0] = 1'b0;
    chk("illegal_sets_err", 64'(perr[0]), 64'h1);
    idle(4);
    txn(0, 0, 32'h40, 32'h40, 64'hA1A1_0000_0000_0001, 64'hA2A2_0000_0000_0002,
        64'hA3A3_0000_0000_0003, 64'hA4A4_0000_0000_0004, 4, 0);
    idle(2);

    // Reset after beat 1 of an overwrite: beats 0,1 committed, 2,3 keep prior data.
    txn(0, 1, 32'h60, 32'h60, 64'h5050_0000_0000_0000, 64'h5151_1111_1111_1111,
        64'h5252_2222_2222_2222, 64'h5353_3333_3333_3333, 4, 0);
    idle(2);
    txn(0, 1, 32'h60, 32'h60, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
        64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD, 2, 1);
    idle(2);
    chk("reset_clears_err", 64'(perr[0]), 64'h0);
    txn(0, 0, 32'h60, 32'h60, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
        64'h5252_2222_2222_2222, 64'h5353_3333_3333_3333, 4, 0);
    idle(2);

    // Address change during WAIT is ignored; then an early drop after two beats.
    txn(0, 1, 32'h80, 32'h80, 64'h0123_4567_89AB_CDEF, 64'h1123_4567_89AB_CDEF,
        64'h2123_4567_89AB_CDEF, 64'h3123_4567_89AB_CDEF, 4, 0);
    idle(2);
    txn(0, 0, 32'h80, 32'h40, 64'h0123_4567_89AB_CDEF, 64'h1123_4567_89AB_CDEF,
        64'h2123_4567_89AB_CDEF, 64'h3123_4567_89AB_CDEF, 4, 0);
    idle(2);
    chk("no_err_before_drop", 64'(perr[0]), 64'h0);
    txn(0, 0, 32'h80, 32'h80, 64'h0123_4567_89AB_CDEF, 64'h1123_4567_89AB_CDEF,
        64'h2123_4567_89AB_CDEF, 64'h3123_4567_89AB_CDEF, 2, 0);
    idle(4);
    chk("early_drop_err", 64'(perr[0]), 64'h1);
    txn(0, 0, 32'h60, 32'h60, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
        64'h5252_2222_2222_2222, 64'h5353_3333_3333_3333, 4, 0);
    idle(2);
    chk("err_sticky", 64'(perr[0]), 64'h1);

    // Latency sweep on the LATENCY=1 and LATENCY=37 instances.
    for (int u = 1; u < 3; u++) begin
      txn(u, 1, 32'h100, 32'h100, 64'h7000_0000_0000_0007, 64'h7100_0000_0000_0017,
          64'h7200_0000_0000_0027, 64'h7300_0000_0000_0037, 4, 0);
      idle(2);
      txn(u, 0, 32'h100, 32'h100, 64'h7000_0000_0000_0007, 64'h7100_0000_0000_0017,
          64'h7200_0000_0000_0027, 64'h7300_0000_0000_0037, 4, 0);
      idle(2);
      chk("latency_inst_no_err", 64'(perr[u]), 64'h0);
    end

    idle(5);
    for (int u = 0; u < 3; u++) chk("scoreboard_drained", 64'(sb[u].size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
